// File: rtl/ram_resp_pkg.sv
// ram_resp_pkg
// Shared definitions for the banked RAM responder:
//   bank_state_e  - per-bank FSM state (IDLE / BUSY / DONE)
//   CNT_W         - width of the per-bank latency down-counter
//   LFSR_SEED     - base seed of the per-bank jitter LFSR (XORed with bank index)
//   lfsr_next()   - one step of the 8-bit Fibonacci LFSR, taps 8,6,5,4
package ram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bank_state_e;

    localparam int CNT_W = 4;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Taps 8,6,5,4 (1-based) map to bits 7,5,4,3; shift towards the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

endpackage

// File: rtl/ram_resp_bank.sv
// ram_resp_bank
// One independent bank of the responder: a DEPTH x 32-bit array, a
// three-state FSM (IDLE -> [BUSY ->] DONE -> IDLE) and a latency down-counter.
// Optional build macro: RAM_RESP_JITTER_EN adds an 8-bit LFSR per bank whose
// low two bits are added to LATENCY at each acceptance.
//
// Handshake: ren/wen are level requests held by the initiator. The bank
// accepts on a rising edge while IDLE; complete is high for exactly one cycle
// (the DONE state) and the initiator drops its request in that cycle. Any
// request still high during the following IDLE cycle is a new request.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (also zeroes the array)
//   ren, wen   - read / write request (write wins if both high)
//   addr       - byte address; word index = addr[log2(DEPTH)+1:2]
//   store      - write data
//   data       - read data, valid only in DONE after a read, else 0
//   complete   - one-cycle completion pulse
//   state_dbg  - current FSM state, for observation
module ram_resp_bank
    import ram_resp_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int LATENCY  = 2,      // legal range 1..15
    parameter int BANK_IDX = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] store,
    output logic [31:0] data,
    output logic        complete,
    output logic [1:0]  state_dbg
);

    localparam int AW = $clog2(DEPTH);

`ifdef RAM_RESP_JITTER_EN
    // Jitter can push the latency up to LATENCY+3, beyond the plain counter range.
    localparam int CW = CNT_W + 1;
`else
    localparam int CW = CNT_W;
`endif

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    bank_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          is_read_q, is_read_d;
    logic [31:0]   mem_q [DEPTH];

    logic          accept;
    logic          mem_we;
    logic [AW-1:0] idx;
    logic [CW-1:0] eff_lat;

    // Address bits outside the word index are deliberately ignored (wrap).
    logic unused_addr;
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

    assign idx    = addr[AW+1:2];
    assign accept = (state_q == IDLE) && (ren || wen);

`ifdef RAM_RESP_JITTER_EN
    logic [7:0] lfsr_q, lfsr_d;

    // The current LFSR value is used for this acceptance, then it advances.
    assign eff_lat = CW'(LATENCY) + CW'(lfsr_q[1:0]);
    assign lfsr_d  = accept ? lfsr_next(lfsr_q) : lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED ^ 8'(BANK_IDX);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign eff_lat = CW'(LATENCY);
`endif

    // State register and datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            is_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            is_read_q <= is_read_d;
        end
    end

    // Array: zeroed by reset, written at the accepting edge of a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx] <= store;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (eff_lat == CNT_ONE) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = eff_lat - CNT_ONE;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Acceptance-time datapath: write commit or read capture.
    always_comb begin
        rdata_d   = rdata_q;
        is_read_d = is_read_q;
        mem_we    = 1'b0;
        if (accept) begin
            is_read_d = !wen;
            mem_we    = wen;
            if (!wen) begin
                rdata_d = mem_q[idx];
            end
        end
    end

    // Outputs.
    always_comb begin
        complete  = (state_q == DONE);
        data      = (state_q == DONE && is_read_q) ? rdata_q : 32'h0;
        state_dbg = state_q;
    end

endmodule

// File: rtl/banked_ram_responder.sv
// banked_ram_responder
// NUM_BANKS independent RAM responder banks sharing one clock and reset.
// Each bank accepts a held read/write request and pulses ram_mem_complete
// LATENCY cycles after acceptance. Optional build macro RAM_RESP_JITTER_EN
// adds per-bank pseudo-random extra latency of 0..3 cycles.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   ram_mem_REN/WEN   - per-bank read / write requests
//   ram_mem_addr      - per-bank byte address
//   ram_mem_store     - per-bank write data
//   ram_mem_data      - per-bank read data (0 unless completing a read)
//   ram_mem_complete  - per-bank one-cycle completion pulse
//   dbg_bank_state    - per-bank FSM state, for observation
module banked_ram_responder
    import ram_resp_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_BANKS-1:0]       ram_mem_REN,
    input  logic [NUM_BANKS-1:0]       ram_mem_WEN,
    input  logic [NUM_BANKS-1:0][31:0] ram_mem_addr,
    input  logic [NUM_BANKS-1:0][31:0] ram_mem_store,
    output logic [NUM_BANKS-1:0][31:0] ram_mem_data,
    output logic [NUM_BANKS-1:0]       ram_mem_complete,
    output logic [NUM_BANKS-1:0][1:0]  dbg_bank_state
);

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        ram_resp_bank #(
            .DEPTH    (DEPTH),
            .LATENCY  (LATENCY),
            .BANK_IDX (g)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .ren       (ram_mem_REN[g]),
            .wen       (ram_mem_WEN[g]),
            .addr      (ram_mem_addr[g]),
            .store     (ram_mem_store[g]),
            .data      (ram_mem_data[g]),
            .complete  (ram_mem_complete[g]),
            .state_dbg (dbg_bank_state[g])
        );
    end

endmodule

// File: tb/tb_banked_ram_responder.sv
// tb_banked_ram_responder
// Directed checks of the banked RAM responder with NUM_BANKS=4, DEPTH=256,
// LATENCY=2. With RAM_RESP_JITTER_EN defined, expected latencies come from a
// reference LFSR model instead of the fixed value.
module tb_banked_ram_responder;

    localparam int NB = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NB-1:0]       ren;
    logic [NB-1:0]       wen;
    logic [NB-1:0][31:0] addr;
    logic [NB-1:0][31:0] store;
    logic [NB-1:0][31:0] data;
    logic [NB-1:0]       complete;
    logic [NB-1:0][1:0]  dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    banked_ram_responder #(
        .NUM_BANKS (NB),
        .DEPTH     (256),
        .LATENCY   (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ram_mem_REN      (ren),
        .ram_mem_WEN      (wen),
        .ram_mem_addr     (addr),
        .ram_mem_store    (store),
        .ram_mem_data     (data),
        .ram_mem_complete (complete),
        .dbg_bank_state   (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

`ifdef RAM_RESP_JITTER_EN
    logic [7:0] m_lfsr [NB];

    task automatic model_reset();
        for (int b = 0; b < NB; b++) m_lfsr[b] = 8'hA5 ^ 8'(b);
    endtask

    function automatic int next_lat(input int b);
        int l;
        l = 2 + int'(m_lfsr[b][1:0]);
        m_lfsr[b] = {m_lfsr[b][6:0], m_lfsr[b][7] ^ m_lfsr[b][5] ^ m_lfsr[b][4] ^ m_lfsr[b][3]};
        return l;
    endfunction
`else
    task automatic model_reset();
    endtask

    function automatic int next_lat(input int b);
        return (b >= 0) ? 2 : 2;
    endfunction
`endif

    // Issue one request on bank b, hold it until complete, then check
    // latency (in cycles after acceptance), completion data and pulse width.
    task automatic req(input int b, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] s,
                       input logic [31:0] exp_d, input string tag);
        int lat_exp;
        int seen;
        lat_exp = next_lat(b);
        @(negedge clk);
        ren[b] = r; wen[b] = w; addr[b] = a; store[b] = s;
        seen = 0;
        for (int i = 1; i <= 24 && seen == 0; i++) begin
            @(negedge clk);
            if (complete[b]) seen = i;
        end
        ren[b] = 1'b0; wen[b] = 1'b0;
        check({tag, "_lat"}, 32'(seen), 32'(lat_exp + 1));
        check({tag, "_data"}, data[b], exp_d);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(complete[b]), 32'h0);
    endtask

    initial begin
        int first_c;
        int second_c;
        int cnt;
        logic [31:0] held_d;

        rst = 1'b1; ren = '0; wen = '0; addr = '0; store = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_complete", 32'(complete), 32'h0);
        for (int b = 0; b < NB; b++) check("rst_data", data[b], 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        rst = 1'b0;

`ifndef RAM_RESP_JITTER_EN
        // All banks read together: identical latency, data 0.
        @(negedge clk);
        ren = '1;
        for (int b = 0; b < NB; b++) addr[b] = 32'h40;
        first_c = 0;
        for (int i = 1; i <= 24 && first_c == 0; i++) begin
            @(negedge clk);
            if (complete != '0) first_c = i;
        end
        ren = '0;
        check("par_lat", 32'(first_c), 32'd3);
        check("par_all", 32'(complete), 32'hF);
        for (int b = 0; b < NB; b++) check("par_data", data[b], 32'h0);
        @(negedge clk);
        check("par_pulse", 32'(complete), 32'h0);
`endif

        // Write then read back on bank 0; bank 1 same address stays 0.
        req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, "wr0");
        req(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "rd0");
        req(1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, "rd1_iso");

        // Address wrap and ignored byte-offset bits.
        req(2, 1'b0, 1'b1, 32'h400, 32'h1234, 32'h0, "wr_wrap");
        req(2, 1'b1, 1'b0, 32'h000, 32'h0, 32'h1234, "rd_wrap");
        req(2, 1'b1, 1'b0, 32'h403, 32'h0, 32'h1234, "rd_lowbits");

        // REN and WEN together act as a write.
        req(3, 1'b1, 1'b1, 32'h20, 32'h55, 32'h0, "rw_both");
        req(3, 1'b1, 1'b0, 32'h20, 32'h0, 32'h55, "rd_both");

`ifndef RAM_RESP_JITTER_EN
        // A request held through DONE is re-accepted in the next IDLE cycle.
        @(negedge clk);
        ren[0] = 1'b1; addr[0] = 32'h10;
        first_c = 0; second_c = 0; held_d = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (complete[0]) begin
                if (first_c == 0) begin
                    first_c = i; held_d = data[0];
                end else if (second_c == 0) begin
                    second_c = i;
                end
            end
        end
        ren[0] = 1'b0;
        check("held_first", 32'(first_c), 32'd3);
        check("held_second", 32'(second_c), 32'd7);
        check("held_data", held_d, 32'hDEADBEEF);
        @(negedge clk);
`endif

        // Reset one cycle after acceptance: no completion, array cleared.
        @(negedge clk);
        wen[0] = 1'b1; addr[0] = 32'h30; store[0] = 32'hCAFE;
        @(negedge clk);
        rst = 1'b1; wen[0] = 1'b0;
        #1;
        check("rstmid_complete", 32'(complete), 32'h0);
        check("rstmid_data", data[0], 32'h0);
        check("rstmid_state", 32'(dbg_state), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (complete[0]) cnt++;
        end
        check("rstmid_no_pulse", 32'(cnt), 32'h0);
        req(0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h0, "rst_rd30");
        req(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, "rst_rd10");

`ifdef RAM_RESP_JITTER_EN
        // 50 reads on bank 1; latency follows the reference LFSR.
        for (int i = 0; i < 50; i++) begin
            req(1, 1'b1, 1'b0, 32'(i * 4), 32'h0, 32'h0, "jit");
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/banked_ram_responder.md
BANKED_RAM_RESPONDER -- requirements
Module: banked_ram_responder

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4: number of independent banks.
REQ-002 SHALL have parameter DEPTH, default 256: 32-bit words per bank, power of two.
REQ-003 SHALL have parameter LATENCY, default 2: cycles from request acceptance to completion; legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port ram_mem_REN, input, NUM_BANKS bits: per-bank read request, held by the initiator until complete.
REQ-007 SHALL have port ram_mem_WEN, input, NUM_BANKS bits: per-bank write request, held by the initiator until complete.
REQ-008 SHALL have port ram_mem_addr, input, NUM_BANKS x 32 bits: per-bank byte address.
REQ-009 SHALL have port ram_mem_store, input, NUM_BANKS x 32 bits: per-bank write data.
REQ-010 SHALL have port ram_mem_data, output, NUM_BANKS x 32 bits: per-bank read data.
REQ-011 SHALL have port ram_mem_complete, output, NUM_BANKS bits: per-bank one-cycle completion pulse.

Function
REQ-012 Each bank SHALL run an independent FSM with states IDLE, BUSY and DONE.
REQ-013 In IDLE, a bank SHALL accept a request on the rising edge where its REN or WEN bit is high, and SHALL ignore both bits in BUSY and DONE.
REQ-014 If REN and WEN are both high at acceptance, the bank SHALL treat the request as a write.
REQ-015 Word index SHALL be ram_mem_addr[log2(DEPTH)+1:2]; bits [1:0] and upper bits SHALL be ignored, so out-of-range addresses wrap.
REQ-016 A write SHALL commit ram_mem_store to the array at the acceptance edge.
REQ-017 A read SHALL capture array data at the acceptance edge into a per-bank data register.
REQ-018 For a request accepted at edge k, ram_mem_complete SHALL be high exactly during the cycle after edge k+LATENCY.
REQ-019 When LATENCY=1, the bank SHALL go IDLE->DONE directly; otherwise it SHALL go IDLE->BUSY and load a down-counter with LATENCY-1, then go BUSY->DONE when the counter reaches 0.
REQ-020 DONE SHALL last exactly one cycle, then the bank SHALL return to IDLE.
REQ-021 The initiator deasserts its request in the complete cycle; a request still high in the following IDLE cycle SHALL be accepted as a new request.
REQ-022 ram_mem_data for a bank SHALL equal the captured read data while that bank is in DONE for a read, and SHALL be 0 otherwise, including writes.
REQ-023 Banks SHALL never share state; simultaneous requests on all banks SHALL complete in the same cycle when latencies are equal.

Reset
REQ-024 While rst is high, every bank SHALL be IDLE, counters 0, ram_mem_complete = 0 and ram_mem_data = 0.
REQ-025 rst SHALL zero all array contents.
REQ-026 rst asserted mid-operation SHALL discard in-flight requests; no complete pulse SHALL follow.
REQ-027 After rst deasserts, the first accepting edge SHALL be the first rising edge with rst low.

Configuration
REQ-028 With macro RAM_RESP_JITTER_EN defined, each bank SHALL have an 8-bit Fibonacci LFSR (taps 8,6,5,4) seeded to 8'hA5 XOR bank index, which advances once per accepted request.
REQ-029 With RAM_RESP_JITTER_EN defined, the effective latency SHALL be LATENCY + lfsr[1:0], sampled at acceptance.
REQ-030 Without RAM_RESP_JITTER_EN, latency SHALL be exactly LATENCY and no LFSR SHALL exist.

Structure
REQ-031 Package ram_resp_pkg SHALL hold the bank-state enum (IDLE, BUSY, DONE), the LFSR seed constant, and the 4-bit counter width.
REQ-032 Sub-module ram_resp_bank SHALL implement one bank (FSM, counter, array, optional LFSR), instantiated NUM_BANKS times by generate.

Verification
REQ-033 Write then read: WEN bank0, addr 0x10, store 0xDEADBEEF; after complete, REN bank0 addr 0x10 -> complete 2 cycles after acceptance, data 0xDEADBEEF.
REQ-034 Parallel requests: reads on all 4 banks in the same cycle after reset -> all complete in the same cycle, data 0, no cross-bank interference.
REQ-035 Wrap: write 0x1234 to addr 0x400 (DEPTH=256) -> read addr 0x000 returns 0x1234.
REQ-036 REN+WEN together: store 0x55 -> treated as a write; data 0 during complete; a later read returns 0x55.
REQ-037 Reset mid-BUSY: rst pulse 1 cycle after acceptance -> no complete pulse, array reads 0 afterwards.
REQ-038 Jitter (macro on): 50 reads on bank1 -> every latency in 2..5, matching a reference LFSR model seeded 0xA4.
